sum_stage_fifo: RTL and testbench
=================================

// Module: sum_stage_fifo
// PURPOSE
//  - Operand-pair adder stage with an elastic buffer: accepts (a,b), computes {carry,sum} = a+b,
//    and queues results for the downstream consumer of the 16-bit sum / carry nets.
//  - Decouples the producer of operand pairs from the sum consumer via valid/ready on both sides.
//  - Single clock domain. Sits directly upstream of the block that consumes sum, carry and data_bus.
// PARAMETERS
//  - DATA_W   16  operand and sum width; the carry is an extra MSB stored per entry
//  - DEPTH    16  number of entries; must be a power of two and >= 2
//  - ADDR_W   $clog2(DEPTH)  derived, not overridden
// PORTS
//  - clk        in   1         the only clock; all state updates on posedge
//  - rst_n      in   1         reset: synchronous and active-low, single clock
//  - in_valid   in   1         operand pair present
//  - in_a       in   DATA_W    operand a
//  - in_b       in   DATA_W    operand b
//  - in_ready   out  1         space available
//  - out_valid  out  1         head entry present
//  - out_sum    out  DATA_W    head sum
//  - out_carry  out  1         head carry
//  - out_ready  in   1         consumer accepts head
//  - count      out  ADDR_W+1  current occupancy, 0..DEPTH
//  - peak       out  ADDR_W+1  high-water mark (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (rst_n low at posedge):
//    - wr_ptr = rd_ptr = 0, count = 0, peak = 0.
//    - out_valid = 0.
//    - in_ready = 0 while rst_n is low, then 1 on the first cycle after release.
//    - Storage contents are don't-care.
//  - Push = in_valid & in_ready. Stores {carry,sum} = {1'b0,in_a} + {1'b0,in_b}; sum wraps mod 2^DATA_W.
//  - Pop = out_valid & out_ready.
//  - Pointers:
//    - ADDR_W+1 bits each; index = low ADDR_W bits; natural wrap from DEPTH-1 to 0.
//    - full  = MSBs differ and low bits equal.
//    - empty = pointers equal.
//  - Outputs:
//    - in_ready = rst_n & ~full; it is not combinationally dependent on out_ready.
//    - out_valid = ~empty.
//    - out_sum / out_carry = mem[rd_ptr] read combinationally; they hold stable while out_valid=1 and out_ready=0.
//  - Latency: a push in cycle N gives out_valid=1 in cycle N+1 if the FIFO was empty.
//  - Simultaneous events:
//    - Push and pop in the same cycle: count unchanged, both pointers advance.
//    - When full, in_ready=0 even if a pop occurs that cycle; the slot is usable next cycle.
//    - When empty, a push with out_ready=1 does not pop (out_valid=0 that cycle).
//  - count updates as count + push - pop, registered.
//  - Reset mid-operation discards all entries; out_valid drops the cycle after the reset edge.
// CONFIGURATION
//  - SUM_STAGE_FIFO_PEAK_EN defined:
//    - peak register = max(peak, count_next), updated every cycle.
//    - Cleared only by reset; saturates at DEPTH.
//  - SUM_STAGE_FIFO_PEAK_EN undefined:
//    - No peak register is built; the peak port is tied to 0.
//    - All other behaviour is identical.
// STRUCTURE
//  - Package sum_stage_pkg:
//    - DATA_W_DEF=16 and DEPTH_DEF=16.
//    - typedef entry_t = struct {carry, sum[DATA_W-1:0]}.
//    - function is_pow2 for an elaboration check of DEPTH.
//  - Sub-module sum_stage_mem:
//    - DEPTH x (DATA_W+1) array, synchronous write port, asynchronous read port.
//    - The top level holds the adder, pointers, flags, count and peak.
// TESTING
//  - Reset then idle -> count=0, out_valid=0, in_ready=1; peak=0 in both builds.
//  - Push a=16'h0001,b=16'h0002 with out_ready=0 -> next cycle out_valid=1, out_sum=3, out_carry=0, count=1.
//  - Push a=16'hFFFF,b=16'h0001 -> out_sum=16'h0000, out_carry=1.
//  - Fill 16 entries of a=i,b=0 with no pops:
//    - in_ready=0, count=16.
//    - A further in_valid is ignored.
//    - Popping returns sums 0..15 in order with wrap; count returns to 0.
//  - Full and push+pop in the same cycle -> only the pop occurs, count=15; the next-cycle push is accepted, count=16.
//  - Fill 5 entries, drain all, then assert reset with 3 entries queued:
//    - After reset, out_valid=0 and count=0.
//    - peak=5 with SUM_STAGE_FIFO_PEAK_EN defined; peak=0 after reset.
//    - peak=0 throughout without the macro.

Source files
------------

// File: rtl/sum_stage_pkg.sv
// sum_stage_pkg: shared defaults, entry type and depth check for the sum stage FIFO
//   DATA_W_DEF / DEPTH_DEF : default operand width and FIFO depth
//   entry_t                : one stored result, {carry, sum}
//   is_pow2                : elaboration-time power-of-two test
package sum_stage_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 16;
    typedef struct packed {
        logic                  carry;
        logic [DATA_W_DEF-1:0] sum;
    } entry_t;
    function automatic bit is_pow2(int n);
        return n > 0 && (n & (n - 1)) == 0;
    endfunction
endpackage

// File: rtl/sum_stage_fifo_if.sv
// sum_stage_fifo_if: operand-in / result-out valid-ready bundle
//   in_valid, in_a, in_b, in_ready    : producer side (operand pairs)
//   out_valid, out_sum, out_carry, out_ready : consumer side (results)
//   master = producer/consumer environment, slave = the FIFO
interface sum_stage_fifo_if
    import sum_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              in_valid, in_ready, out_valid, out_carry, out_ready;
    logic [DATA_W-1:0] in_a, in_b, out_sum;
    modport master (output in_valid, in_a, in_b, out_ready,
                    input  in_ready, out_valid, out_sum, out_carry);
    modport slave  (input  in_valid, in_a, in_b, out_ready,
                    output in_ready, out_valid, out_sum, out_carry);
endinterface

// File: rtl/sum_stage_mem.sv
// sum_stage_mem: DEPTH x W storage, synchronous write, asynchronous read
//   clk     : clock
//   we_i    : write enable
//   waddr_i : write index,  wdata_i : write data
//   raddr_i : read index,   rdata_o : read data (combinational)
module sum_stage_mem #(
    parameter  int W      = 17,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [W-1:0]      wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [W-1:0]      rdata_o
);
    logic [W-1:0] mem_q [DEPTH];
    always_ff @(posedge clk)
        if (we_i) mem_q[waddr_i] <= wdata_i;
    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sum_stage_fifo.sv
// sum_stage_fifo: a+b adder feeding an elastic FIFO of {carry, sum} results
//   clk   : clock, rst_n : synchronous active-low reset
//   bus   : sum_stage_fifo_if.slave (operand in / result out handshakes)
//   count : occupancy 0..DEPTH
//   peak  : high-water mark when SUM_STAGE_FIFO_PEAK_EN is defined, else tied to 0
module sum_stage_fifo
    import sum_stage_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    sum_stage_fifo_if.slave   bus,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W:0]   peak
);
    localparam logic [ADDR_W:0] ONE = 1;
    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
        $error("sum_stage_fifo: DEPTH must be a power of two >= 2");
    end
    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
    logic            full, empty, push, pop;
    logic [DATA_W:0] wdata, rdata;
    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign empty = wr_ptr_q == rd_ptr_q;
    // in_ready looks only at registered state, so a same-cycle pop cannot free a full slot.
    assign bus.in_ready  = rst_n & ~full;
    assign bus.out_valid = ~empty;
    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;
    assign wdata = {1'b0, bus.in_a} + {1'b0, bus.in_b};
    assign {bus.out_carry, bus.out_sum} = rdata;
    assign count = count_q;
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + ONE : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + ONE : rd_ptr_q;
        count_d  = (push && !pop) ? count_q + ONE :
                   (pop && !push) ? count_q - ONE : count_q;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
`ifdef SUM_STAGE_FIFO_PEAK_EN
    logic [ADDR_W:0] peak_q, peak_d;
    // count never exceeds DEPTH, so the peak saturates there naturally.
    assign peak_d = (count_d > peak_q) ? count_d : peak_q;
    always_ff @(posedge clk)
        if (!rst_n) peak_q <= '0;
        else        peak_q <= peak_d;
    assign peak = peak_q;
`else
    assign peak = '0;
`endif
    sum_stage_mem #(.W(DATA_W + 1), .DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i (wdata),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (rdata)
    );
endmodule

// File: tb/tb_sum_stage_fifo.sv
// tb_sum_stage_fifo: directed self-checking bench for sum_stage_fifo
module tb_sum_stage_fifo;
`ifdef SUM_STAGE_FIFO_PEAK_EN
    localparam bit PK = 1'b1;
`else
    localparam bit PK = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] count, peak;
    int         errors = 0;
    int         checks = 0;
    sum_stage_fifo_if #(.DATA_W(16)) bus ();
    sum_stage_fifo #(.DATA_W(16), .DEPTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .count (count),
        .peak  (peak)
    );
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic logic [31:0] pk(input int n);
        return PK ? 32'(n) : 32'd0;
    endfunction
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        check("in_ready_in_reset", 32'(bus.in_ready), 0);
        check("out_valid_in_reset", 32'(bus.out_valid), 0);
        rst_n = 1'b1;
        step();
        check("idle_count", 32'(count), 0);
        check("idle_out_valid", 32'(bus.out_valid), 0);
        check("idle_in_ready", 32'(bus.in_ready), 1);
        check("idle_peak", 32'(peak), 0);
        // 1 + 2, consumer stalled
        bus.in_valid = 1'b1; bus.in_a = 16'h0001; bus.in_b = 16'h0002;
        step();
        bus.in_valid = 1'b0;
        check("p1_out_valid", 32'(bus.out_valid), 1);
        check("p1_sum", 32'(bus.out_sum), 32'h3);
        check("p1_carry", 32'(bus.out_carry), 0);
        check("p1_count", 32'(count), 1);
        check("p1_peak", 32'(peak), pk(1));
        step();
        check("p1_hold_sum", 32'(bus.out_sum), 32'h3);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("p1_drained_count", 32'(count), 0);
        check("p1_drained_valid", 32'(bus.out_valid), 0);
        // FFFF + 1 wraps with carry
        bus.in_valid = 1'b1; bus.in_a = 16'hFFFF; bus.in_b = 16'h0001;
        step();
        bus.in_valid = 1'b0;
        check("wrap_sum", 32'(bus.out_sum), 32'h0);
        check("wrap_carry", 32'(bus.out_carry), 1);
        check("wrap_count", 32'(count), 1);
        bus.out_ready = 1'b1;
        step();
        check("wrap_drained", 32'(count), 0);
        // push into empty FIFO while out_ready=1: no pop that cycle
        bus.in_valid = 1'b1; bus.in_a = 16'h0010; bus.in_b = 16'h0020;
        step();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        check("empty_push_count", 32'(count), 1);
        check("empty_push_sum", 32'(bus.out_sum), 32'h30);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("empty_push_drained", 32'(count), 0);
        // fill all 16 entries with a=i, b=0
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = 1'b1; bus.in_a = 16'(i); bus.in_b = 16'h0;
            step();
        end
        check("full_in_ready", 32'(bus.in_ready), 0);
        check("full_count", 32'(count), 16);
        check("full_peak", 32'(peak), pk(16));
        bus.in_a = 16'h0099;
        step();
        check("full_ignored_count", 32'(count), 16);
        check("full_head", 32'(bus.out_sum), 0);
        // full with push+pop: only the pop happens
        bus.in_a = 16'h0100; bus.out_ready = 1'b1;
        step();
        check("full_pp_count", 32'(count), 15);
        check("full_pp_in_ready", 32'(bus.in_ready), 1);
        bus.out_ready = 1'b0;
        step();
        bus.in_valid = 1'b0;
        check("refill_count", 32'(count), 16);
        for (int i = 1; i < 16; i++) begin
            check($sformatf("drain_%0d", i), 32'(bus.out_sum), 32'(i));
            bus.out_ready = 1'b1;
            step();
            bus.out_ready = 1'b0;
        end
        check("drain_last", 32'(bus.out_sum), 32'h100);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("drain_count", 32'(count), 0);
        check("drain_valid", 32'(bus.out_valid), 0);
        // reset clears peak
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("reset2_peak", 32'(peak), 0);
        check("reset2_count", 32'(count), 0);
        // fill 5, drain, queue 3, reset mid-operation
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1; bus.in_a = 16'(i); bus.in_b = 16'h000A;
            step();
        end
        bus.in_valid = 1'b0;
        check("fill5_count", 32'(count), 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("fill5_sum_%0d", i), 32'(bus.out_sum), 32'(i + 10));
            bus.out_ready = 1'b1;
            step();
            bus.out_ready = 1'b0;
        end
        check("fill5_drained", 32'(count), 0);
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1; bus.in_a = 16'h1000; bus.in_b = 16'(i);
            step();
        end
        bus.in_valid = 1'b0;
        check("q3_count", 32'(count), 3);
        check("q3_peak", 32'(peak), pk(5));
        rst_n = 1'b0;
        step();
        check("mid_reset_valid", 32'(bus.out_valid), 0);
        check("mid_reset_count", 32'(count), 0);
        check("mid_reset_peak", 32'(peak), 0);
        check("mid_reset_in_ready", 32'(bus.in_ready), 0);
        rst_n = 1'b1;
        step();
        check("post_reset_valid", 32'(bus.out_valid), 0);
        check("post_reset_in_ready", 32'(bus.in_ready), 1);
        check("post_reset_count", 32'(count), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
